imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory stage that sits directly upstream of the single-cycle `mips` core and drives its `instr` port. After reset it holds the core in reset and accepts a length-prefixed program image as a byte stream over a valid/ready handshake. It packs the bytes into 32-bit words and writes them into an internal word-addressed instruction RAM. When the image is complete it releases the core and serves `instr = imem[pc]` combinationally.

## Interface
Parameters:
- `ADDR_WIDTH`, 6: word-address width; RAM depth = 2**ADDR_WIDTH words (default 64).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  program image byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `pc`  in  32  core program counter (byte address).
- `instr`  out  32  instruction for `pc`, combinational.
- `cpu_reset`  out  1  reset for the `mips` core; registered.
- `done`  out  1  image loaded, core running.
- `error`  out  1  header word count exceeded RAM depth.
- `loaded_words`  out  16  word count N from the header.

## Operation
- Image format: 2-byte big-endian word count N, then N words, each 4 bytes big-endian (MSB first).
- A byte is accepted on a rising edge where `rx_valid && rx_ready`.
- FSM states:
  - `CNT_HI`: accept a byte, latch it as `N[15:8]`, go to `CNT_LO`.
  - `CNT_LO`: accept a byte, latch it as `N[7:0]`.
    - If N == 0, go to `RUN`.
    - If N > 2**ADDR_WIDTH, go to `ERROR`.
    - Otherwise go to `WORDS`.
  - `WORDS`:
    - Shift each accepted byte into a 24-bit assembly register; a 2-bit byte counter tracks position.
    - On the 4th byte, write `{asm[23:0], rx_data}` to `imem[widx]` and increment `widx`.
    - When `widx` reaches N on that same edge, go to `RUN`.
  - `RUN`: terminal until reset.
  - `ERROR`: terminal until reset.
- `rx_ready` = !reset && state ∈ {`CNT_HI`, `CNT_LO`, `WORDS`}. It is 0 in `RUN` and `ERROR`; bytes offered there are not consumed.
- `instr` rules:
  - Word index = `pc[ADDR_WIDTH+1:2]`; `pc[1:0]` is ignored.
  - `instr` = 32'h0 (NOP) if any of `pc[31:ADDR_WIDTH+2]` is nonzero.
  - `instr` = 32'h0 if word index >= `loaded_words`.
  - `instr` = 32'h0 if state != `RUN`.
- `cpu_reset` = 1 in every state except `RUN`. `done` = (state == `RUN`). `error` = (state == `ERROR`).
- RAM contents are not cleared by reset. Stale words are masked by the `loaded_words` comparison.

## Timing
- Reset values:
  - state = `CNT_HI`, `cpu_reset` = 1, `done` = 0, `error` = 0, `loaded_words` = 0.
  - `widx` = 0, byte counter = 0.
  - `rx_ready` = 0 while `reset` is high.
- At most one byte is accepted per cycle; back-to-back acceptance is allowed.
- A RAM write occurs on the same edge that accepts the 4th byte of a word.
- `cpu_reset` falls on the edge that accepts the final byte, or the `CNT_LO` byte when N == 0. The core's first cycle out of reset sees the full image.
- `instr` has zero-cycle latency from `pc` (async read).
- If `rx_valid` drops mid-word, the FSM waits with partial assembly preserved. There is no timeout.
- Reset asserted mid-load: return to `CNT_HI`, discard any partial word, reassert `cpu_reset`. Words already written stay in RAM but are masked.
- `loaded_words` updates on the `CNT_LO` edge.

## Structure
- Shared package `mips_pkg`:
  - `loader_state_t` enum (`CNT_HI`, `CNT_LO`, `WORDS`, `RUN`, `ERROR`).
  - Constant `INSTR_NOP` = 32'h0000_0000.
- Sub-module `imem_ram`: 2**ADDR_WIDTH × 32 storage with synchronous write (`we`, `waddr`, `wdata`) and asynchronous read (`raddr`, `rdata`).
- The FSM, assembly register, masking and `cpu_reset` register live in `imem_loader`.

## Test plan
- **Normal load.** Stream 00 02 20 08 00 05 AC 08 00 3C with `rx_valid` held high.
  - `cpu_reset` falls the edge after the 10th byte; `done` = 1.
  - pc = 0 → 20080005; pc = 4 → AC08003C; pc = 8 → 00000000.
- **Stalled stream.** Same image with `rx_valid` low for 3 cycles between bytes 5 and 6.
  - Identical RAM contents; no extra writes; `cpu_reset` stays high until the last byte.
- **Zero-length image.** Stream 00 00.
  - `RUN` after 2 bytes; `loaded_words` = 0; `instr` = 0 for all pc.
  - `rx_ready` = 0 thereafter; a further offered byte is not consumed.
- **Oversize image.** Stream 00 41 (N = 65 > 64).
  - `error` = 1, `cpu_reset` stays 1, `rx_ready` = 0, `instr` = 0.
- **Reset mid-word.** Reset after 2 bytes of word 1, then reload with N = 1, word 12345678.
  - pc = 0 → 12345678; pc = 4 → 0, stale word masked.
  - pc = 32'h0000_0100 → 0, out of range.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the mips core and its boot-time loader.
package mips_pkg;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    WORDS,
    RUN,
    ERROR
  } loader_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Word-addressed instruction RAM.
// Synchronous write and asynchronous read; contents are never cleared.
module imem_ram
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed byte image into instruction RAM,
// then releases the core and serves instructions for its pc.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] loaded_words
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  loader_state_t         state_q;
  logic [7:0]            hi_q;
  logic [15:0]           cnt_q;
  logic [23:0]           asm_q;
  logic [1:0]            bcnt_q;
  logic [ADDR_WIDTH:0]   widx_q;
  logic                  cpu_reset_q;

  logic                  acc;
  logic                  we;
  logic [15:0]           hdr;
  logic [ADDR_WIDTH:0]   widx_nx;
  logic                  wr_last;
  logic [ADDR_WIDTH-1:0] ridx;
  logic                  pc_hi_nz;
  logic [31:0]           rdata;
  logic                  unused_pc;

  assign rx_ready = !reset &&
    (state_q == CNT_HI || state_q == CNT_LO || state_q == WORDS);
  assign acc     = rx_valid && rx_ready;
  assign hdr     = {hi_q, rx_data};
  assign we      = acc && state_q == WORDS && bcnt_q == 2'd3;
  assign widx_nx = widx_q + 1'b1;
  assign wr_last = 16'(widx_nx) == cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CNT_HI;
      hi_q        <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      bcnt_q      <= '0;
      widx_q      <= '0;
      cpu_reset_q <= 1'b1;
    end else if (acc) begin
      unique case (state_q)
        CNT_HI: begin
          hi_q    <= rx_data;
          state_q <= CNT_LO;
        end
        CNT_LO: begin
          cnt_q <= hdr;
          if (hdr == 16'd0) begin
            state_q     <= RUN;
            cpu_reset_q <= 1'b0;
          end else if (32'(hdr) > DEPTH) begin
            state_q <= ERROR;
          end else begin
            state_q <= WORDS;
          end
        end
        WORDS: begin
          asm_q  <= {asm_q[15:0], rx_data};
          bcnt_q <= bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            widx_q <= widx_nx;
            if (wr_last) begin
              state_q     <= RUN;
              cpu_reset_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  imem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(widx_q[ADDR_WIDTH-1:0]),
    .wdata({asm_q, rx_data}),
    .raddr(ridx),
    .rdata(rdata)
  );

  assign ridx      = pc[ADDR_WIDTH+1:2];
  assign pc_hi_nz  = |(pc >> (ADDR_WIDTH + 2));
  assign unused_pc = ^pc[1:0];

  // Anything not freshly loaded, or out of range, reads as a NOP.
  assign instr = (state_q == RUN && !pc_hi_nz && 16'(ridx) < cnt_q)
               ? rdata : INSTR_NOP;

  assign cpu_reset    = cpu_reset_q;
  assign done         = state_q == RUN;
  assign error        = state_q == ERROR;
  assign loaded_words = cnt_q;

endmodule
